melody_sequencer: RTL

Parametrised tune player that drives the piezo `BEEP` output from a melody ROM. It replaces per-song hard-coded pitch tables with an external ROM port, configurable song and note counts, and a tempo derived from `CLK_HZ`. It adds start/stop control, looping, a done pulse and exact note durations. It sits between the front-panel control logic (debounced buttons, mode/song registers) and the buzzer pin.

---
 rtl/melody_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// Melody ROM player driving a piezo square wave, with start/stop, looping and a done pulse.
// Define MELODY_SEQ_GAP_EN to insert GAP_CYC silent cycles after every note.
module melody_sequencer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BEAT_HZ = 8,
  parameter int SONG_W  = 3,
  parameter int IDX_W   = 6,
  parameter int HP_W    = 20,
  parameter int GAP_CYC = 500_000
) (
  input  logic                     CK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     STOP,
  input  logic [SONG_W-1:0]        SONG,
  input  logic                     LOOP,
  input  logic                     MUTE,
  output logic [SONG_W+IDX_W-1:0]  ROM_ADDR,
  input  logic [4+HP_W-1:0]        ROM_DATA,
  output logic                     BEEP,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [IDX_W-1:0]         NOTE_IDX
);

  localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;
  localparam int DUR_W    = $clog2(16 * BEAT_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  if (BEAT_DIV < 2) begin : g_beatChk
    $error("melody_sequencer: CLK_HZ/BEAT_HZ must be at least 2");
  end
  if (GAP_CYC < 1) begin : g_gapChk
    $error("melody_sequencer: GAP_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY
`ifdef MELODY_SEQ_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t             r_state;
  logic [SONG_W-1:0]  r_song;
  logic [IDX_W-1:0]   r_idx;
  logic [HP_W-1:0]    r_hp;
  logic [3:0]         r_dur;
  logic [HP_W-1:0]    r_toneCnt;
  logic [DUR_W-1:0]   r_durCnt;
  logic               r_phase;
  logic               r_beep;
  logic               r_busy;
  logic               r_done;

`ifdef MELODY_SEQ_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  logic [GAP_W-1:0]   r_gapCnt;
`endif

  logic [HP_W-1:0]    w_hpIn;
  logic [3:0]         w_durIn;
  logic               w_isEnd;
  logic [DUR_W-1:0]   w_durLast;

  assign w_hpIn    = ROM_DATA[HP_W-1:0];
  assign w_durIn   = ROM_DATA[HP_W+3:HP_W];
  assign w_isEnd   = &w_hpIn;
  assign w_durLast = DUR_W'((int'(r_dur) + 1) * BEAT_DIV - 1);

  // The phase register keeps the tone running while MUTE blanks only the output register.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_song    <= '0;
      r_idx     <= '0;
      r_hp      <= '0;
      r_dur     <= '0;
      r_toneCnt <= '0;
      r_durCnt  <= '0;
      r_phase   <= 1'b0;
      r_beep    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MELODY_SEQ_GAP_EN
      r_gapCnt  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (STOP) begin
        r_state <= S_IDLE;
        r_phase <= 1'b0;
        r_beep  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_beep <= 1'b0;
            if (START) begin
              r_song  <= SONG;
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_FETCH;
            end
          end
          S_FETCH: r_state <= S_LOAD;
          S_LOAD: begin
            r_hp  <= w_hpIn;
            r_dur <= w_durIn;
            if (w_isEnd) begin
              if (LOOP) begin
                r_idx   <= '0;
                r_state <= S_FETCH;
              end else begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_toneCnt <= '0;
              r_durCnt  <= '0;
              r_phase   <= 1'b0;
              r_state   <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (r_durCnt == w_durLast) begin
              r_phase <= 1'b0;
              r_beep  <= 1'b0;
`ifdef MELODY_SEQ_GAP_EN
              r_gapCnt <= '0;
              r_state  <= S_GAP;
`else
              // The last ROM slot behaves as if followed by an end marker.
              if (r_idx == IDX_LAST) begin
                if (LOOP) begin
                  r_idx   <= '0;
                  r_state <= S_FETCH;
                end else begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end
              end else begin
                r_idx   <= r_idx + IDX_W'(1);
                r_state <= S_FETCH;
              end
`endif
            end else begin
              r_durCnt <= r_durCnt + DUR_W'(1);
              if (r_hp == '0) begin
                r_beep <= 1'b0;
              end else if (r_toneCnt == r_hp - HP_W'(1)) begin
                r_toneCnt <= '0;
                r_phase   <= ~r_phase;
                r_beep    <= ~r_phase & ~MUTE;
              end else begin
                r_toneCnt <= r_toneCnt + HP_W'(1);
                r_beep    <= r_phase & ~MUTE;
              end
            end
          end
`ifdef MELODY_SEQ_GAP_EN
          S_GAP: begin
            r_beep <= 1'b0;
            if (r_gapCnt == GAP_LAST) begin
              if (r_idx == IDX_LAST) begin
                if (LOOP) begin
                  r_idx   <= '0;
                  r_state <= S_FETCH;
                end else begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end
              end else begin
                r_idx   <= r_idx + IDX_W'(1);
                r_state <= S_FETCH;
              end
            end else begin
              r_gapCnt <= r_gapCnt + GAP_W'(1);
            end
          end
`endif
          default: begin
            r_beep  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ROM_ADDR = {r_song, r_idx};
  assign NOTE_IDX = r_idx;
  assign BEEP     = r_beep;
  assign BUSY     = r_busy;
  assign DONE     = r_done;

endmodule
